nn_lut_interp: RTL and testbench

Pipelined linear interpolator that sits directly downstream of a layer's activation-function `my_lut` table. It splits each signed fixed-point pre-activation sample into a table address and a fraction, and drives the address to the LUT. It then combines the returned `base`/`next__data` pair into an interpolated activation value. Valid/ready handshakes on both sides allow back-to-back operation and bubble collapsing under backpressure.

---
 rtl/nn_lut_interp.sv | 102 ++++++++++
 tb/tb_nn_lut_interp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_lut_interp.sv
// nn_lut_interp: three-stage linear interpolator behind an activation LUT.
// Stage A holds the sample and addresses the LUT, stage B captures the
// base/next pair plus fraction, stage C holds the interpolated result.
// Each stage has its own valid bit so bubbles collapse under backpressure.
module nn_lut_interp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] lut_address,
  input  logic [DATA_W-1:0] lut_base,
  input  logic [DATA_W-1:0] lut_next,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);
  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int PW     = DATA_W + FRAC_W + 2;

  // vld_pipe[0]=A, [1]=B, [2]=C
  logic [2:0]               vld_pipe;
  logic [DATA_W-1:0]        a_q;
  logic signed [DATA_W-1:0] b_base, b_next;
  logic [FRAC_W-1:0]        b_frac;
  logic [DATA_W-1:0]        c_q;

  logic ld_a, adv_a, ld_b, adv_b, ld_c;

  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0]   diff_x, frac_x, base_x, prod, sum;

  // Advance chain, evaluated from the output end backwards
  always_comb begin
    ld_c  = !vld_pipe[2] | out_ready;
    adv_b = vld_pipe[1] & ld_c;
    ld_b  = !vld_pipe[1] | adv_b;
    adv_a = vld_pipe[0] & ld_b;
    ld_a  = !vld_pipe[0] | adv_a;
  end

  assign in_ready    = ld_a;
  assign lut_address = a_q[DATA_W-1:FRAC_W];
  assign out_valid   = vld_pipe[2];
  assign out_data    = c_q;
  assign busy        = |vld_pipe;

  // Interpolation: base + floor((next-base)*frac / 2^FRAC_W); always within
  // [base, next], so the truncation to DATA_W below is lossless.
  always_comb begin
    diff   = $signed({b_next[DATA_W-1], b_next}) - $signed({b_base[DATA_W-1], b_base});
    diff_x = PW'(diff);
    frac_x = PW'($signed({1'b0, b_frac}));
    base_x = PW'(b_base);
    prod   = diff_x * frac_x;
    sum    = base_x + (prod >>> FRAC_W);
  end

  // Stage A: capture the sample on an input transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[0] <= 1'b0;
      a_q         <= '0;
    end else if (ld_a) begin
      vld_pipe[0] <= in_valid;
      if (in_valid) a_q <= in_data;
    end
  end

  // Stage B: capture the LUT pair and the unsigned fraction from A
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      b_base      <= '0;
      b_next      <= '0;
      b_frac      <= '0;
    end else if (ld_b) begin
      vld_pipe[1] <= vld_pipe[0];
      if (adv_a) begin
        b_base <= lut_base;
        b_next <= lut_next;
        b_frac <= a_q[FRAC_W-1:0];
      end
    end
  end

  // Stage C: register the interpolated result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      c_q         <= '0;
    end else if (ld_c) begin
      vld_pipe[2] <= vld_pipe[1];
      if (adv_b) c_q <= sum[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_nn_lut_interp.sv
// Directed bench for nn_lut_interp with a behavioural LUT next to the DUT.
module tb_nn_lut_interp;
  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [7:0]        in_data;
  logic [3:0]        lut_address;
  logic signed [7:0] lut_base, lut_next;
  logic              out_valid, out_ready;
  logic [7:0]        out_data;
  logic              busy;

  logic signed [7:0] lut [16];

  int pass_cnt = 0, tot = 0;
  int acc_cnt = 0, cyc = 0, trunc_err = 0, stall_err = 0;
  logic [7:0] inq[$], outq[$];
  int incyc[$], outcyc[$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  nn_lut_interp #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .lut_address(lut_address), .lut_base(lut_base),
    .lut_next(lut_next), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // LUT: address 7 clamps, address 15 wraps to 0
  assign lut_base = lut[lut_address];
  assign lut_next = (lut_address == 4'd7) ? lut[7] : lut[4'(lut_address + 4'd1)];

  // Transfer monitor, stall-stability and truncation watch
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (in_valid && in_ready) begin
        inq.push_back(in_data); incyc.push_back(cyc); acc_cnt++;
      end
      if (out_valid && out_ready) begin
        outq.push_back(out_data); outcyc.push_back(cyc);
      end
      if (prev_stall && out_data !== prev_data) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (dut.vld_pipe[1] && (dut.sum > 127 || dut.sum < -128)) trunc_err++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [7:0] model(input logic [7:0] x);
    int a, base, nx, p;
    a    = int'(x[7:4]);
    base = int'(lut[a]);
    nx   = (a == 7) ? int'(lut[7]) : int'(lut[(a + 1) % 16]);
    p    = (nx - base) * int'(x[3:0]);
    return 8'(base + (p >>> 4));
  endfunction

  task automatic set_identity();
    for (int i = 0; i < 16; i++) lut[i] = 8'(((i < 8) ? i : i - 16) * 16);
  endtask

  // Offer one sample (called just after a negedge); returns after acceptance
  task automatic push(input logic [7:0] x);
    int n;
    n = acc_cnt;
    in_valid = 1'b1;
    in_data  = x;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc_cnt != n) break;
    end
    if (acc_cnt == n) begin
      tot++;
      $display("FAIL push_timeout sample=%h not accepted within 200 cycles", x);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int maxc);
    for (int k = 0; k < maxc && outq.size() < n; k++) @(negedge clk);
  endtask

  task automatic clear_q();
    inq.delete(); outq.delete(); incyc.delete(); outcyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tot++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    tot++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", out_data); else pass_cnt++;
    tot++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    tot++; if (lut_address !== 4'h0) $display("FAIL reset_lut_address got %h want 0", lut_address); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h25;
    @(negedge clk);
    in_valid = 1'b0;
    tot++; if (lut_address !== 4'd2) $display("FAIL basic_addr got %0d want 2", lut_address); else pass_cnt++;
    tot++; if (out_valid !== 1'b0) $display("FAIL basic_valid_e1 got %b want 0", out_valid); else pass_cnt++;
    @(negedge clk);
    tot++; if (out_valid !== 1'b0) $display("FAIL basic_valid_e2 got %b want 0", out_valid); else pass_cnt++;
    @(negedge clk);
    tot++; if (out_valid !== 1'b1) $display("FAIL basic_valid_e3 got %b want 1", out_valid); else pass_cnt++;
    tot++; if (out_data !== 8'd37) $display("FAIL basic_data got %0d want 37", $signed(out_data)); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    logic [7:0] vin [4];
    logic [7:0] vexp [4];
    vin  = '{8'h7F, 8'hFF, 8'h80, 8'h00};
    vexp = '{8'd112, 8'hFF, 8'h80, 8'h00};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear_q();
      push(vin[i]);
      wait_out(1, 10);
      tot++;
      if (outq.size() != 1) $display("FAIL bound_%h count got %0d want 1", vin[i], outq.size());
      else if (outq[0] !== vexp[i]) $display("FAIL bound_%h got %h want %h", vin[i], outq[0], vexp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_stream();
    logic [7:0] xs [16];
    out_ready = 1'b1;
    clear_q();
    for (int i = 0; i < 16; i++) xs[i] = 8'(i * 17);
    for (int i = 0; i < 16; i++) push(xs[i]);
    wait_out(16, 10);
    tot++; if (outq.size() != 16) $display("FAIL stream_count got %0d want 16", outq.size()); else pass_cnt++;
    for (int i = 0; i < 16 && i < outq.size(); i++) begin
      tot++;
      if (outq[i] !== model(xs[i])) $display("FAIL stream_%0d got %h want %h", i, outq[i], model(xs[i]));
      else pass_cnt++;
    end
    if (incyc.size() == 16 && outcyc.size() == 16) begin
      tot++;
      if (incyc[15] - incyc[0] != 15) $display("FAIL stream_in_gap span got %0d want 15", incyc[15] - incyc[0]); else pass_cnt++;
      tot++;
      if (outcyc[15] - outcyc[0] != 15) $display("FAIL stream_out_gap span got %0d want 15", outcyc[15] - outcyc[0]); else pass_cnt++;
      tot++;
      if (outcyc[0] - incyc[0] != 3) $display("FAIL stream_latency got %0d want 3", outcyc[0] - incyc[0]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bp [6];
    bp = '{8'h25, 8'h3A, 8'h41, 8'h5C, 8'h6F, 8'h13};
    out_ready = 1'b0;
    clear_q();
    for (int i = 0; i < 3; i++) push(bp[i]);
    tot++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else pass_cnt++;
    tot++; if (busy !== 1'b1) $display("FAIL bp_busy got %b want 1", busy); else pass_cnt++;
    tot++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got %b want 1", out_valid); else pass_cnt++;
    tot++; if (out_data !== 8'd37) $display("FAIL bp_out_data got %h want 25", out_data); else pass_cnt++;
    in_valid = 1'b1; in_data = bp[3];
    repeat (3) @(negedge clk);
    tot++; if (out_data !== 8'd37) $display("FAIL bp_hold_data got %h want 25", out_data); else pass_cnt++;
    tot++; if (inq.size() != 3) $display("FAIL bp_accepted got %0d want 3", inq.size()); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) push(bp[i]);
    wait_out(6, 20);
    tot++; if (outq.size() != 6) $display("FAIL bp_count got %0d want 6", outq.size()); else pass_cnt++;
    for (int i = 0; i < 6 && i < outq.size(); i++) begin
      tot++;
      if (outq[i] !== model(bp[i])) $display("FAIL bp_%0d got %h want %h", i, outq[i], model(bp[i]));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    clear_q();
    push(8'h25); push(8'h30); push(8'h41);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tot++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", out_valid); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else pass_cnt++;
    tot++; if (out_data !== 8'h00) $display("FAIL rmid_out_data got %h want 00", out_data); else pass_cnt++;
    tot++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    clear_q();
    push(8'h10);
    wait_out(1, 10);
    repeat (3) @(negedge clk);
    tot++;
    if (outq.size() != 1) $display("FAIL rmid_count got %0d want 1", outq.size());
    else if (outq[0] !== 8'd16) $display("FAIL rmid_data got %h want 10", outq[0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] xs[$];
    logic [7:0] ex[$];
    bit done;
    int bad;
    for (int i = 0; i < 16; i++) lut[i] = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      xs.push_back(8'($urandom));
      ex.push_back(model(xs[i]));
    end
    clear_q();
    done = 1'b0;
    stall_err = 0; trunc_err = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          push(xs[i]);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b1;
    wait_out(40, 20);
    tot++; if (outq.size() != 40) $display("FAIL rand_count got %0d want 40", outq.size()); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 40 && i < outq.size(); i++)
      if (outq[i] !== ex[i]) begin
        bad++;
        $display("FAIL rand_%0d in=%h got %h want %h", i, xs[i], outq[i], ex[i]);
      end
    tot++; if (bad != 0) $display("FAIL rand_data got %0d wrong want 0", bad); else pass_cnt++;
    tot++; if (stall_err != 0) $display("FAIL rand_stall_stable got %0d changes want 0", stall_err); else pass_cnt++;
    tot++; if (trunc_err != 0) $display("FAIL rand_truncation got %0d overflows want 0", trunc_err); else pass_cnt++;
  endtask

  initial begin
    set_identity();
    test_reset();
    test_basic();
    test_boundaries();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
